sync_period_sched: RTL and testbench

- Generates the design-wide sync pulse train in the user_clk domain.
- Period comes from the sync_period software register (32-bit user_data_out); mode and arming come from a second control software register.
- Optionally aligns the first pulse to an external sync/PPS edge. Period updates are applied only at pulse boundaries so downstream accumulators never see a glitched frame.
- Sits between the ppc2simulink registers and the sync consumers (FFT, accumulator, snapshot).

---
 rtl/sync_sched_pkg.sv | 18 +
 rtl/rise_detect.sv | 18 +
 rtl/sync_period_sched.sv | 115 +++++++++++
 tb/tb_sync_period_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_sched_pkg.sv
// Shared types and constants for the sync pulse scheduler.
package sync_sched_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_ALIGN = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } sched_state_e;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_ALIGN    = 2;
    localparam int unsigned CTRL_TRIG     = 3;

    localparam int unsigned PERIOD_MIN_DEFAULT = 2;

endpackage

// File: rtl/rise_detect.sv
// 1-bit rising-edge detector: registered previous value, combinational edge flag.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/sync_period_sched.sv
// Sync pulse train generator: periodic or one-shot, optionally aligned to an
// external/soft trigger edge; period changes take effect only at a fire.
module sync_period_sched
    import sync_sched_pkg::*;
#(
    parameter int unsigned PULSE_W    = 1,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PERIOD_MIN = PERIOD_MIN_DEFAULT
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    input  logic [CNT_W-1:0] period_in,
    input  logic [31:0]      ctrl_in,
    input  logic             ext_sync_in,
    output logic             sync_out,
    output logic [CNT_W-1:0] sync_cnt,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] period_active
);

    localparam logic [CNT_W-1:0] PMIN       = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [3:0]       PULSE_LAST = 4'(PULSE_W - 1);

    sched_state_e     state;
    logic [CNT_W-1:0] down_cnt;
    logic [3:0]       hi_cnt;
    logic [CNT_W-1:0] eff_period;
    logic             ext_rise;
    logic             trig_rise;
    logic             fire;
    logic             en;
    logic             periodic;
    logic             align;
    logic             ctrl_unused;

    assign en          = ctrl_in[CTRL_EN];
    assign periodic    = ctrl_in[CTRL_PERIODIC];
    assign align       = ctrl_in[CTRL_ALIGN];
    assign ctrl_unused = ^ctrl_in[31:4];

    rise_detect u_ext_rise (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .d     (ext_sync_in),
        .rise  (ext_rise)
    );

    rise_detect u_trig_rise (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .d     (ctrl_in[CTRL_TRIG]),
        .rise  (trig_rise)
    );

    always_comb begin
        eff_period = (period_in < PMIN) ? PMIN : period_in;
        fire = en && (((state == WAIT_ALIGN) && (ext_rise || trig_rise)) ||
                      ((state == RUN) && (down_cnt == '0)));
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state         <= IDLE;
            sync_out      <= 1'b0;
            sync_cnt      <= '0;
            period_active <= PMIN;
            down_cnt      <= '0;
            hi_cnt        <= '0;
        end else if (!en) begin
            state    <= IDLE;
            sync_out <= 1'b0;
            hi_cnt   <= '0;
        end else begin
            if (fire) begin
                sync_out      <= 1'b1;
                hi_cnt        <= PULSE_LAST;
                sync_cnt      <= sync_cnt + ONE;
                period_active <= eff_period;
                down_cnt      <= eff_period - ONE;
            end else begin
                if (sync_out) begin
                    if (hi_cnt != '0) hi_cnt   <= hi_cnt - 4'd1;
                    else              sync_out <= 1'b0;
                end
                if (state == RUN) down_cnt <= down_cnt - ONE;
            end

            case (state)
                IDLE: begin
                    // Zero counter makes the first RUN cycle fire immediately.
                    sync_cnt      <= '0;
                    period_active <= eff_period;
                    down_cnt      <= '0;
                    state         <= align ? WAIT_ALIGN : RUN;
                end
                WAIT_ALIGN: begin
                    period_active <= eff_period;
                    if (fire) state <= RUN;
                end
                RUN: begin
                    if (!periodic && !fire && sync_out && (hi_cnt == '0))
                        state <= DONE;
                end
                DONE: begin
                    sync_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_sync_period_sched.sv
// Directed bench for sync_period_sched; cycle k counts negedges after the
// control write, so a fire on posedge k is seen at sample k.
module tb_sync_period_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] period_in;
    logic [31:0] ctrl;
    logic        ext;

    logic        s1, s4;
    logic [31:0] c1, c4, pa1, pa4;
    logic [1:0]  st1, st4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sync_period_sched #(.PULSE_W(1), .CNT_W(32), .PERIOD_MIN(2)) dut (
        .user_clk      (clk),
        .user_rst_n    (rst_n),
        .period_in     (period_in),
        .ctrl_in       (ctrl),
        .ext_sync_in   (ext),
        .sync_out      (s1),
        .sync_cnt      (c1),
        .state_out     (st1),
        .period_active (pa1)
    );

    sync_period_sched #(.PULSE_W(4), .CNT_W(32), .PERIOD_MIN(5)) dut4 (
        .user_clk      (clk),
        .user_rst_n    (rst_n),
        .period_in     (period_in),
        .ctrl_in       (ctrl),
        .ext_sync_in   (ext),
        .sync_out      (s4),
        .sync_cnt      (c4),
        .state_out     (st4),
        .period_active (pa4)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_gap();
        ctrl = 32'h0;
        ext  = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ctrl = 32'h0; ext = 1'b0; period_in = 32'd10;
        step();
        step();
        vectors++; if (s1 !== 1'b0)   begin miscompares++; $display("FAIL reset_out got=%b exp=0", s1); end
        vectors++; if (c1 !== 32'd0)  begin miscompares++; $display("FAIL reset_cnt got=%0d exp=0", c1); end
        vectors++; if (st1 !== 2'd0)  begin miscompares++; $display("FAIL reset_state got=%0d exp=0", st1); end
        vectors++; if (pa1 !== 32'd2) begin miscompares++; $display("FAIL reset_period got=%0d exp=2", pa1); end
        vectors++; if (pa4 !== 32'd5) begin miscompares++; $display("FAIL reset_period4 got=%0d exp=5", pa4); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_periodic();
        logic e;
        period_in = 32'd10; ctrl = 32'h3;
        for (int k = 1; k <= 45; k++) begin
            step();
            e = (k >= 2) && ((k - 2) % 10 == 0);
            vectors++; if (s1 !== e) begin miscompares++; $display("FAIL periodic_out k=%0d got=%b exp=%b", k, s1, e); end
        end
        vectors++; if (c1 !== 32'd5)  begin miscompares++; $display("FAIL periodic_cnt got=%0d exp=5", c1); end
        vectors++; if (st1 !== 2'd2)  begin miscompares++; $display("FAIL periodic_state got=%0d exp=2", st1); end
        vectors++; if (pa1 !== 32'd10) begin miscompares++; $display("FAIL periodic_period got=%0d exp=10", pa1); end
        ctrl = 32'h0;
        step();
        vectors++; if (st1 !== 2'd0) begin miscompares++; $display("FAIL disable_state got=%0d exp=0", st1); end
        vectors++; if (c1 !== 32'd5) begin miscompares++; $display("FAIL disable_cnt_hold got=%0d exp=5", c1); end
        idle_gap();
    endtask

    task automatic test_min_period();
        logic e;
        period_in = 32'd1; ctrl = 32'h3;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin
                vectors++; if (c1 !== 32'd0) begin miscompares++; $display("FAIL minp_cnt_clear got=%0d exp=0", c1); end
            end
            e = (k >= 2) && (k % 2 == 0);
            vectors++; if (s1 !== e) begin miscompares++; $display("FAIL minp_out k=%0d got=%b exp=%b", k, s1, e); end
        end
        vectors++; if (pa1 !== 32'd2) begin miscompares++; $display("FAIL minp_period got=%0d exp=2", pa1); end
        vectors++; if (c1 !== 32'd6)  begin miscompares++; $display("FAIL minp_cnt got=%0d exp=6", c1); end
        period_in = 32'd0;
        step();
        step();
        vectors++; if (pa1 !== 32'd2) begin miscompares++; $display("FAIL zerop_period got=%0d exp=2", pa1); end
        idle_gap();
    endtask

    task automatic test_align();
        logic e;
        logic [1:0] es;
        period_in = 32'd10; ctrl = 32'h7; ext = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            es = (k <= 36) ? 2'd1 : 2'd2;
            e  = (k == 37) || (k == 47) || (k == 57);
            vectors++; if (st1 !== es) begin miscompares++; $display("FAIL align_state k=%0d got=%0d exp=%0d", k, st1, es); end
            vectors++; if (s1 !== e)   begin miscompares++; $display("FAIL align_out k=%0d got=%b exp=%b", k, s1, e); end
            ext = ((k >= 36) && (k <= 39)) || ((k >= 41) && (k <= 44));
            if (k == 50) ctrl = 32'h3;
        end
        vectors++; if (c1 !== 32'd3) begin miscompares++; $display("FAIL align_cnt got=%0d exp=3", c1); end
        idle_gap();
    endtask

    task automatic test_trig_and_ext();
        logic e;
        period_in = 32'd10; ctrl = 32'h7; ext = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            e = (k == 4) || (k == 14);
            vectors++; if (s1 !== e) begin miscompares++; $display("FAIL trig_out k=%0d got=%b exp=%b", k, s1, e); end
            if (k == 3) begin ext = 1'b1; ctrl = 32'hF; end
        end
        vectors++; if (c1 !== 32'd2) begin miscompares++; $display("FAIL trig_single_fire_cnt got=%0d exp=2", c1); end
        idle_gap();
    endtask

    task automatic test_period_change();
        logic e;
        period_in = 32'd8; ctrl = 32'h3;
        for (int k = 1; k <= 50; k++) begin
            step();
            e = (k == 2) || (k == 10) || (k == 18) || (k == 38) || (k == 43) || (k == 48);
            vectors++; if (s1 !== e) begin miscompares++; $display("FAIL pchg_out k=%0d got=%b exp=%b", k, s1, e); end
            if (k == 17) begin vectors++; if (pa1 !== 32'd8)  begin miscompares++; $display("FAIL pchg_pa17 got=%0d exp=8", pa1); end end
            if (k == 18) begin vectors++; if (pa1 !== 32'd20) begin miscompares++; $display("FAIL pchg_pa18 got=%0d exp=20", pa1); end end
            if (k == 38) begin vectors++; if (pa1 !== 32'd5)  begin miscompares++; $display("FAIL pchg_pa38 got=%0d exp=5", pa1); end end
            if (k == 13) period_in = 32'd20;
            if (k == 37) period_in = 32'd5;
        end
        idle_gap();
    endtask

    task automatic test_period_max();
        logic e;
        period_in = 32'hFFFF_FFFF; ctrl = 32'h3;
        for (int k = 1; k <= 40; k++) begin
            step();
            e = (k == 2);
            vectors++; if (s1 !== e) begin miscompares++; $display("FAIL pmax_out k=%0d got=%b exp=%b", k, s1, e); end
        end
        vectors++; if (pa1 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL pmax_period got=%h exp=ffffffff", pa1); end
        vectors++; if (st1 !== 2'd2) begin miscompares++; $display("FAIL pmax_state got=%0d exp=2", st1); end
        vectors++; if (c1 !== 32'd1) begin miscompares++; $display("FAIL pmax_cnt got=%0d exp=1", c1); end
        idle_gap();
    endtask

    task automatic test_one_shot();
        logic e;
        period_in = 32'd10; ctrl = 32'h1;
        for (int k = 1; k <= 100; k++) begin
            step();
            e = (k == 2);
            vectors++; if (s1 !== e) begin miscompares++; $display("FAIL oneshot_out k=%0d got=%b exp=%b", k, s1, e); end
            if (k >= 3) begin
                vectors++; if (st1 !== 2'd3) begin miscompares++; $display("FAIL oneshot_state k=%0d got=%0d exp=3", k, st1); end
            end
        end
        vectors++; if (c1 !== 32'd1) begin miscompares++; $display("FAIL oneshot_cnt got=%0d exp=1", c1); end
        ctrl = 32'h0;
        step();
        vectors++; if (st1 !== 2'd0) begin miscompares++; $display("FAIL oneshot_idle got=%0d exp=0", st1); end
        ctrl = 32'h1;
        step();
        vectors++; if (c1 !== 32'd0) begin miscompares++; $display("FAIL rearm_cnt_clear got=%0d exp=0", c1); end
        step();
        vectors++; if (s1 !== 1'b1)  begin miscompares++; $display("FAIL rearm_out got=%b exp=1", s1); end
        vectors++; if (c1 !== 32'd1) begin miscompares++; $display("FAIL rearm_cnt got=%0d exp=1", c1); end
        step();
        vectors++; if (s1 !== 1'b0)  begin miscompares++; $display("FAIL rearm_out_end got=%b exp=0", s1); end
        vectors++; if (st1 !== 2'd3) begin miscompares++; $display("FAIL rearm_state got=%0d exp=3", st1); end
        idle_gap();
    endtask

    task automatic test_truncate();
        logic e;
        period_in = 32'd10; ctrl = 32'h3;
        for (int k = 1; k <= 13; k++) begin
            step();
            e = ((k >= 2) && (k <= 5)) || (k >= 12);
            vectors++; if (s4 !== e) begin miscompares++; $display("FAIL wide_out k=%0d got=%b exp=%b", k, s4, e); end
        end
        ctrl = 32'h0;
        step();
        vectors++; if (s4 !== 1'b0)  begin miscompares++; $display("FAIL trunc_out got=%b exp=0", s4); end
        vectors++; if (st4 !== 2'd0) begin miscompares++; $display("FAIL trunc_state got=%0d exp=0", st4); end
        vectors++; if (c4 !== 32'd2) begin miscompares++; $display("FAIL trunc_cnt got=%0d exp=2", c4); end
        step();
    endtask

    task automatic test_reset_mid_pulse();
        period_in = 32'd10; ctrl = 32'h3;
        step();
        step();
        vectors++; if (s4 !== 1'b1)  begin miscompares++; $display("FAIL rstmid_pre_out got=%b exp=1", s4); end
        vectors++; if (c4 !== 32'd1) begin miscompares++; $display("FAIL rstmid_pre_cnt got=%0d exp=1", c4); end
        step();
        rst_n = 1'b0;
        step();
        vectors++; if (s4 !== 1'b0)  begin miscompares++; $display("FAIL rstmid_out got=%b exp=0", s4); end
        vectors++; if (c4 !== 32'd0) begin miscompares++; $display("FAIL rstmid_cnt got=%0d exp=0", c4); end
        vectors++; if (st4 !== 2'd0) begin miscompares++; $display("FAIL rstmid_state got=%0d exp=0", st4); end
        vectors++; if (pa4 !== 32'd5) begin miscompares++; $display("FAIL rstmid_period got=%0d exp=5", pa4); end
        rst_n = 1'b1;
        ctrl  = 32'h0;
        step();
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_min_period();
        test_align();
        test_trig_and_ext();
        test_period_change();
        test_period_max();
        test_one_shot();
        test_truncate();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
